// File: rtl/sram_1p_bm_mbist.sv
// rtl/sram_1p_bm_mbist.sv - single-port bit-masked SRAM model with integrated March C- BIST
//
// Purpose: parametrised single-port SRAM behavioural model (DATA_W x 2**ADDR_W) with a
// per-bit write mask and an on-board March C- engine that takes the array over on START.
//
// Ports:
//   A_CLK         clock, all logic on posedge
//   A_RST         synchronous active-high reset (array contents are not reset)
//   A_MEN         functional memory enable
//   A_WEN/A_REN   functional write/read enables, qualified by A_MEN
//   A_ADDR        functional address
//   A_DIN/A_BM    functional write data and bit mask (1 = bit written)
//   A_DOUT        read data, one edge latency, holds between reads
//   A_BIST_START  start pulse, honoured only when the engine is not busy
//   A_BIST_BUSY   engine owns the array, functional accesses ignored
//   A_BIST_DONE   run complete, held until next START or reset
//   A_BIST_FAIL   sticky mismatch flag for current/last run
//   A_BIST_FADDR  address of first mismatch
//   A_BIST_FBIT   expected XOR read data at first mismatch
//   A_FI_EN       fault-injection enable (only when FI_EN=1)
//   A_FI_ADDR     address whose reads return bit 0 inverted
module sram_1p_bm_mbist #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 9,
    parameter bit FI_EN  = 1'b0
) (
    input  logic              A_CLK,
    input  logic              A_RST,
    input  logic              A_MEN,
    input  logic              A_WEN,
    input  logic              A_REN,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_DIN,
    input  logic [DATA_W-1:0] A_BM,
    output logic [DATA_W-1:0] A_DOUT,
    input  logic              A_BIST_START,
    output logic              A_BIST_BUSY,
    output logic              A_BIST_DONE,
    output logic              A_BIST_FAIL,
    output logic [ADDR_W-1:0] A_BIST_FADDR,
    output logic [DATA_W-1:0] A_BIST_FBIT,
    input  logic              A_FI_EN,
    input  logic [ADDR_W-1:0] A_FI_ADDR
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_M0,
        ST_M1,
        ST_M2,
        ST_M3,
        ST_M4,
        ST_M5,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] baddr_q, baddr_d;
    // In read-then-write elements: 0 = read slot, 1 = write slot of the current address
    logic              phase_q, phase_d;

    // Static description of the current March element
    logic              el_has_rd, el_has_wr, el_rd_ones, el_wr_ones, el_asc;
    state_t            el_next;
    logic [ADDR_W-1:0] el_next_addr;
    logic              el_last_addr;

    logic              op_is_rd;
    logic              b_rd, b_wr;
    logic [DATA_W-1:0] b_wdata, b_exp;

    logic              busy, start_run;
    logic              fn_rd, fn_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] rd_word, merged, fi_mask, mem_wdata;
    logic              mem_we;

    logic [DATA_W-1:0] mem [DEPTH];

    // Two-stage compare: stage 1 holds the expectation of the read that just
    // updated A_DOUT, stage 2 holds the resulting difference for capture.
    logic              cmp1_v, cmp2_v;
    logic [DATA_W-1:0] cmp1_exp, cmp2_xor;
    logic [ADDR_W-1:0] cmp1_addr, cmp2_addr;

    assign busy        = !(state_q == ST_IDLE || state_q == ST_DONE);
    assign start_run   = !busy && A_BIST_START;
    assign A_BIST_BUSY = busy;
    assign A_BIST_DONE = (state_q == ST_DONE);

    always_comb begin
        el_has_rd    = 1'b0;
        el_has_wr    = 1'b0;
        el_rd_ones   = 1'b0;
        el_wr_ones   = 1'b0;
        el_asc       = 1'b1;
        el_next      = ST_IDLE;
        el_next_addr = '0;
        case (state_q)
            ST_M0: begin
                el_has_wr = 1'b1;
                el_next   = ST_M1;
            end
            ST_M1: begin
                el_has_rd  = 1'b1;
                el_has_wr  = 1'b1;
                el_wr_ones = 1'b1;
                el_next    = ST_M2;
            end
            ST_M2: begin
                el_has_rd    = 1'b1;
                el_has_wr    = 1'b1;
                el_rd_ones   = 1'b1;
                el_next      = ST_M3;
                el_next_addr = ADDR_MAX;
            end
            ST_M3: begin
                el_has_rd    = 1'b1;
                el_has_wr    = 1'b1;
                el_wr_ones   = 1'b1;
                el_asc       = 1'b0;
                el_next      = ST_M4;
                el_next_addr = ADDR_MAX;
            end
            ST_M4: begin
                el_has_rd  = 1'b1;
                el_has_wr  = 1'b1;
                el_rd_ones = 1'b1;
                el_asc     = 1'b0;
                el_next    = ST_M5;
            end
            ST_M5: begin
                el_has_rd = 1'b1;
                el_next   = ST_FLUSH;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        baddr_d      = baddr_q;
        phase_d      = phase_q;
        op_is_rd     = 1'b0;
        b_rd         = 1'b0;
        b_wr         = 1'b0;
        b_wdata      = el_wr_ones ? ALL_ONES : '0;
        b_exp        = el_rd_ones ? ALL_ONES : '0;
        el_last_addr = el_asc ? (baddr_q == ADDR_MAX) : (baddr_q == '0);
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (A_BIST_START) begin
                    state_d = ST_M0;
                    baddr_d = '0;
                    phase_d = 1'b0;
                end
            end
            ST_FLUSH: begin
                // Leave once the last read's expectation has moved into stage 2
                if (!cmp1_v) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                op_is_rd = el_has_rd && !phase_q;
                b_rd     = op_is_rd;
                b_wr     = !op_is_rd;
                if (op_is_rd && el_has_wr) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (el_last_addr) begin
                        state_d = el_next;
                        baddr_d = el_next_addr;
                    end else begin
                        baddr_d = el_asc ? baddr_q + ADDR_W'(1) : baddr_q - ADDR_W'(1);
                    end
                end
            end
        endcase
    end

    always_comb begin
        fn_rd     = !busy && A_MEN && A_REN;
        fn_wr     = !busy && A_MEN && A_WEN;
        mem_addr  = busy ? baddr_q : A_ADDR;
        rd_word   = mem[mem_addr];
        merged    = (rd_word & ~A_BM) | (A_DIN & A_BM);
        fi_mask   = (FI_EN && A_FI_EN && (mem_addr == A_FI_ADDR)) ? DATA_W'(1) : '0;
        mem_we    = busy ? b_wr : fn_wr;
        mem_wdata = busy ? b_wdata : merged;
    end

    // A reset edge must not complete an in-flight BIST write
    always_ff @(posedge A_CLK) begin
        if (!A_RST && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            state_q      <= ST_IDLE;
            baddr_q      <= '0;
            phase_q      <= 1'b0;
            A_DOUT       <= '0;
            cmp1_v       <= 1'b0;
            cmp1_exp     <= '0;
            cmp1_addr    <= '0;
            cmp2_v       <= 1'b0;
            cmp2_xor     <= '0;
            cmp2_addr    <= '0;
            A_BIST_FAIL  <= 1'b0;
            A_BIST_FADDR <= '0;
            A_BIST_FBIT  <= '0;
        end else begin
            state_q <= state_d;
            baddr_q <= baddr_d;
            phase_q <= phase_d;

            if (b_rd) begin
                A_DOUT <= rd_word ^ fi_mask;
            end else if (fn_rd) begin
                A_DOUT <= (fn_wr ? merged : rd_word) ^ fi_mask;
            end

            cmp1_v    <= b_rd;
            cmp1_exp  <= b_exp;
            cmp1_addr <= baddr_q;
            cmp2_v    <= cmp1_v;
            cmp2_xor  <= A_DOUT ^ cmp1_exp;
            cmp2_addr <= cmp1_addr;

            if (cmp2_v && (cmp2_xor != '0) && !A_BIST_FAIL) begin
                A_BIST_FAIL  <= 1'b1;
                A_BIST_FADDR <= cmp2_addr;
                A_BIST_FBIT  <= cmp2_xor;
            end

            if (start_run) begin
                A_BIST_FAIL  <= 1'b0;
                A_BIST_FADDR <= '0;
                A_BIST_FBIT  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sram_1p_bm_mbist.sv
// tb/tb_sram_1p_bm_mbist.sv - testbench for sram_1p_bm_mbist
module tb_sram_1p_bm_mbist;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int D  = 16;

    // March C- as a table of elements: direction, read value, write value
    localparam bit EL_ASC [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam bit EL_RD  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam bit EL_RV  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam bit EL_WR  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam bit EL_WV  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    logic          clk = 1'b0;
    logic          rst, men, wen, ren, start, fi_en;
    logic [AW-1:0] addr, fi_addr;
    logic [DW-1:0] din, bm;
    logic [DW-1:0] dout, fbit;
    logic [AW-1:0] faddr;
    logic          busy, done, fail;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_mem [D];
    logic [DW-1:0] model_dout;

    always #5 clk = ~clk;

    sram_1p_bm_mbist #(.DATA_W(DW), .ADDR_W(AW), .FI_EN(1'b1)) dut (
        .A_CLK(clk), .A_RST(rst), .A_MEN(men), .A_WEN(wen), .A_REN(ren),
        .A_ADDR(addr), .A_DIN(din), .A_BM(bm), .A_DOUT(dout),
        .A_BIST_START(start), .A_BIST_BUSY(busy), .A_BIST_DONE(done),
        .A_BIST_FAIL(fail), .A_BIST_FADDR(faddr), .A_BIST_FBIT(fbit),
        .A_FI_EN(fi_en), .A_FI_ADDR(fi_addr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic func_op(input logic m, input logic w, input logic r,
                           input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] b);
        men = m; wen = w; ren = r; addr = a; din = d; bm = b;
        tick();
        men = 1'b0; wen = 1'b0; ren = 1'b0;
        if (m && w) model_mem[a] = (model_mem[a] & ~b) | (d & b);
        if (m && r) model_dout = model_mem[a];
    endtask

    // Walks the March C- algorithm on an abstract array and reports the first
    // miscompare plus the number of operations performed.
    task automatic march_model(input bit fi_on, input int fi_a, output bit f,
                               output int fa, output logic [DW-1:0] fb, output int ops);
        logic [DW-1:0] m [D];
        logic [DW-1:0] got, expv;
        int a;
        f = 1'b0; fa = 0; fb = '0; ops = 0;
        for (int i = 0; i < D; i++) m[i] = '0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < D; i++) begin
                a = EL_ASC[e] ? i : D - 1 - i;
                if (EL_RD[e]) begin
                    got  = m[a] ^ ((fi_on && a == fi_a) ? 8'h01 : 8'h00);
                    expv = EL_RV[e] ? 8'hFF : 8'h00;
                    ops++;
                    if (got != expv && !f) begin
                        f = 1'b1; fa = a; fb = got ^ expv;
                    end
                end
                if (EL_WR[e]) begin
                    m[a] = EL_WV[e] ? 8'hFF : 8'h00;
                    ops++;
                end
            end
        end
    endtask

    // Pulses START, optionally attempts a locked-out access at cycle lock_at,
    // and counts edges until DONE (bounded).
    task automatic run_bist(input int lock_at, output int cycles, output int busy_cnt,
                            output logic [2:0] start_flags);
        start = 1'b1;
        tick();
        start = 1'b0;
        start_flags = {busy, done, fail};
        cycles = 0;
        busy_cnt = 0;
        while (!done && cycles < 400) begin
            if (busy) busy_cnt++;
            if (cycles == lock_at) begin
                men = 1'b1; wen = 1'b1; ren = 1'b1; addr = 4'd3; din = 8'hAA; bm = 8'hFF; start = 1'b1;
            end
            tick();
            cycles++;
            men = 1'b0; wen = 1'b0; ren = 1'b0; start = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; men = 0; wen = 0; ren = 0; start = 0; fi_en = 0;
        fi_addr = '0; addr = '0; din = '0; bm = '0;
        tick();
        tick();
        rst = 1'b0;
        model_dout = '0;
        checks++;
        if ({busy, done, fail} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, fail});
        end
        checks++;
        if (dout !== 8'h00 || faddr !== 4'h0 || fbit !== 8'h00) begin
            errors++; $display("FAIL reset_data: dout=%h faddr=%h fbit=%h expected all 0", dout, faddr, fbit);
        end
    endtask

    task automatic test_masked_write();
        logic [DW-1:0] held;
        for (int a = 0; a < D; a++) func_op(1, 1, 0, AW'(a), DW'($urandom), 8'hFF);
        func_op(1, 1, 0, 4'd5, 8'hFF, 8'hFF);
        func_op(1, 1, 0, 4'd5, 8'h00, 8'h0F);
        func_op(1, 0, 1, 4'd5, 8'h00, 8'h00);
        checks++;
        if (dout !== 8'hF0) begin
            errors++; $display("FAIL masked_write_directed: got %h expected f0", dout);
        end
        held = dout;
        func_op(0, 1, 1, 4'd5, 8'h55, 8'hFF);
        checks++;
        if (dout !== held || model_mem[5] !== 8'hF0) begin
            errors++; $display("FAIL men_low_hold: got %h expected %h", dout, held);
        end
        for (int i = 0; i < 60; i++) begin
            func_op($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                    AW'($urandom), DW'($urandom), DW'($urandom));
            checks++;
            if (dout !== model_dout) begin
                errors++; $display("FAIL random_access[%0d]: got %h expected %h", i, dout, model_dout);
            end
        end
        for (int a = 0; a < D; a++) begin
            func_op(1, 0, 1, AW'(a), 8'h00, 8'h00);
            checks++;
            if (dout !== model_mem[a]) begin
                errors++; $display("FAIL readback[%0d]: got %h expected %h", a, dout, model_mem[a]);
            end
        end
    endtask

    task automatic test_write_through();
        func_op(1, 1, 1, 4'd7, 8'h3C, 8'hFF);
        checks++;
        if (dout !== 8'h3C) begin
            errors++; $display("FAIL write_through_full: got %h expected 3c", dout);
        end
        for (int i = 0; i < 8; i++) begin
            func_op(1, 1, 1, AW'($urandom), DW'($urandom), DW'($urandom));
            checks++;
            if (dout !== model_dout) begin
                errors++; $display("FAIL write_through_masked[%0d]: got %h expected %h", i, dout, model_dout);
            end
        end
    endtask

    task automatic test_bist_clean();
        int cyc, bc, ops, mfa;
        bit mf;
        logic [DW-1:0] mfb;
        logic [2:0] sf;
        march_model(0, 0, mf, mfa, mfb, ops);
        run_bist(20, cyc, bc, sf);
        checks++;
        if (sf !== 3'b100) begin
            errors++; $display("FAIL clean_start_flags: got %b expected 100", sf);
        end
        checks++;
        if (cyc !== ops + 2 || bc !== ops + 2) begin
            errors++; $display("FAIL clean_cycles: done_edge=%0d busy=%0d expected %0d", cyc, bc, ops + 2);
        end
        checks++;
        if (fail !== mf || faddr !== AW'(mfa) || fbit !== mfb || busy !== 1'b0) begin
            errors++; $display("FAIL clean_result: fail=%b faddr=%h fbit=%h busy=%b expected %b %h %h 0",
                               fail, faddr, fbit, busy, mf, AW'(mfa), mfb);
        end
        for (int a = 0; a < D; a++) model_mem[a] = 8'h00;
        for (int a = 0; a < D; a++) begin
            func_op(1, 0, 1, AW'(a), 8'h00, 8'h00);
            checks++;
            if (dout !== model_mem[a]) begin
                errors++; $display("FAIL post_bist_array[%0d]: got %h expected %h", a, dout, model_mem[a]);
            end
        end
    endtask

    task automatic test_bist_fault();
        int cyc, bc, ops, mfa, fa;
        bit mf;
        logic [DW-1:0] mfb;
        logic [2:0] sf;
        for (int run = 0; run < 2; run++) begin
            fa = (run == 0) ? 9 : int'($urandom_range(0, D - 1));
            fi_en = 1'b1;
            fi_addr = AW'(fa);
            march_model(1, fa, mf, mfa, mfb, ops);
            run_bist(-1, cyc, bc, sf);
            checks++;
            if (sf !== 3'b100) begin
                errors++; $display("FAIL fault_start_flags[%0d]: got %b expected 100", run, sf);
            end
            checks++;
            if (cyc !== ops + 2) begin
                errors++; $display("FAIL fault_cycles[%0d]: got %0d expected %0d", run, cyc, ops + 2);
            end
            checks++;
            if (fail !== mf || faddr !== AW'(mfa) || fbit !== mfb) begin
                errors++; $display("FAIL fault_capture[%0d]: fail=%b faddr=%h fbit=%h expected %b %h %h",
                                   run, fail, faddr, fbit, mf, AW'(mfa), mfb);
            end
            men = 1'b1; ren = 1'b1; wen = 1'b0; addr = AW'(fa);
            tick();
            men = 1'b0; ren = 1'b0;
            model_dout = model_mem[fa] ^ 8'h01;
            checks++;
            if (dout !== model_dout) begin
                errors++; $display("FAIL fault_func_read[%0d]: got %h expected %h", run, dout, model_dout);
            end
        end
        fi_en = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int cyc, bc;
        logic [2:0] sf;
        fi_en = 1'b1;
        fi_addr = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (49) tick();
        checks++;
        if (busy !== 1'b1 || fail !== 1'b1) begin
            errors++; $display("FAIL mid_run_state: busy=%b fail=%b expected 1 1", busy, fail);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fi_en = 1'b0;
        model_dout = '0;
        checks++;
        if ({busy, done, fail} !== 3'b000 || dout !== 8'h00) begin
            errors++; $display("FAIL mid_run_reset: flags=%b dout=%h expected 000 00", {busy, done, fail}, dout);
        end
        run_bist(-1, cyc, bc, sf);
        checks++;
        if (cyc !== 10 * D + 2 || bc !== 10 * D + 2 || fail !== 1'b0 || sf !== 3'b100) begin
            errors++; $display("FAIL rerun_after_reset: cycles=%0d busy=%0d fail=%b start=%b expected %0d %0d 0 100",
                               cyc, bc, fail, sf, 10 * D + 2, 10 * D + 2);
        end
    endtask

    initial begin
        test_reset();
        test_masked_write();
        test_write_through();
        test_bist_clean();
        test_bist_fault();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
